serial_link_tx_arbiter: RTL



---
 rtl/serial_link_tx_arbiter_pkg.sv | 27 ++
 rtl/serial_link_tx_arbiter_if.sv | 53 +++++
 rtl/serial_link_tx_arbiter_rr_arbiter.sv | 41 ++++
 rtl/serial_link_tx_arbiter.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/serial_link_tx_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// serial_link_tx_arbiter_pkg
// Shared definitions for the serial link transmit arbiter:
//   - link item field sizes (header / payload / address) and the derived
//     item width used as the default DATA_W of the arbiter,
//   - the debug view the arbiter exposes for its FSM.
// -----------------------------------------------------------------------------
package serial_link_tx_arbiter_pkg;

   // Link item layout, shared with the rest of the serial link blocks.
   localparam int HDR_SZ      = 2;
   localparam int PL_SZ       = 4;
   localparam int ADDR_SZ     = 2;
   localparam int LINK_ITEM_W = HDR_SZ + PL_SZ + ADDR_SZ;

   // Width of the raw FSM state code carried in the debug struct.
   localparam int TX_STATE_W  = 2;

   // Debug view of the transmit FSM.
   //   state     : raw state code (0 idle, 1 send, 2 hold)
   //   hold_done : hold-off interval has elapsed
   typedef struct packed {
      logic [TX_STATE_W-1:0] state;
      logic                  hold_done;
   } tx_dbg_t;

endpackage : serial_link_tx_arbiter_pkg

// File: rtl/serial_link_tx_arbiter_if.sv
// -----------------------------------------------------------------------------
// serial_link_tx_arbiter_if
// Bundles the requester handshake, the receiver back-pressure and the serial
// line of the transmit arbiter.
//
// Signals:
//   req_valid    [N_REQ]         requester i has an item
//   req_data     [N_REQ*DATA_W]  item i is req_data[i*DATA_W +: DATA_W]
//   req_ack      [N_REQ]         one-cycle pulse, item i latched
//   channel_busy                 receiver busy receiving/holding an item
//   serial_out                   registered serial line to the receiver
//   grant_id     [$clog2(N_REQ)] index of the last granted requester
//   link_active                  high while a frame is sent or held off
//   frame_done                   one-cycle pulse on the guard bit
//
// Handshake: a requester raises req_valid[i] with req_data lane i stable and
// keeps both until it sees req_ack[i] high for one cycle; the item is latched
// on that cycle. Dropping req_valid before the ack withdraws the request.
// channel_busy is the only flow control towards the arbiter: no new frame is
// started while it is high.
//
// Modports:
//   master : the requester / environment side
//   slave  : the arbiter side
// -----------------------------------------------------------------------------
interface serial_link_tx_arbiter_if
   import serial_link_tx_arbiter_pkg::*;
#(
   parameter int N_REQ  = 4,
   parameter int DATA_W = LINK_ITEM_W
);
   localparam int IDX_W = $clog2(N_REQ);

   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ*DATA_W-1:0] req_data;
   logic [N_REQ-1:0]        req_ack;
   logic                    channel_busy;
   logic                    serial_out;
   logic [IDX_W-1:0]        grant_id;
   logic                    link_active;
   logic                    frame_done;

   modport master (
      output req_valid, req_data, channel_busy,
      input  req_ack, serial_out, grant_id, link_active, frame_done
   );

   modport slave (
      input  req_valid, req_data, channel_busy,
      output req_ack, serial_out, grant_id, link_active, frame_done
   );

endinterface : serial_link_tx_arbiter_if

// File: rtl/serial_link_tx_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: grants the first asserted request at or
// after index ptr, wrapping around. Written generically so the router output
// ports can reuse it.
//
// Ports:
//   req     [N]          request vector
//   ptr     [$clog2(N)]  highest-priority index for this pick (must be < N)
//   gnt     [N]          one-hot grant, all zero when no request
//   gnt_idx [$clog2(N)]  index of the granted request, 0 when none
// -----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int N     = 4,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] gnt_idx
);

   always_comb begin
      int   idx;
      logic found;
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      idx     = 0;
      // Walk the requests starting at ptr; the first hit wins.
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (!found && req[idx]) begin
            found    = 1'b1;
            gnt[idx] = 1'b1;
            gnt_idx  = IDX_W'(idx);
         end
      end
   end

endmodule : rr_arbiter

// File: rtl/serial_link_tx_arbiter.sv
// -----------------------------------------------------------------------------
// serial_link_tx_arbiter
// Shares one serial link between N_REQ requesters. A round-robin pick latches
// one item, which is sent LSB first as the frame
//    1 (start), d0 .. d[DATA_W-1], 0 (guard)
// one bit per clock on serial_out. The line idles at 0. After each frame the
// link is held off for at least HOLDOFF cycles and until channel_busy from the
// receiver is low before the next frame may start.
//
// Ports:
//   clk      link clock (receiver samples serial_out on the falling edge)
//   reset    asynchronous, active high
//   lnk      slave side of serial_link_tx_arbiter_if (requests, ack,
//            channel_busy, serial_out, grant_id, link_active, frame_done)
//   dbg_o    FSM debug view
//
// Observable timing for a grant whose ack is high in cycle T:
//   start bit in T+1, d_k in T+2+k, guard bit in T+DATA_W+2 with frame_done,
//   link_active high from T+1 until the next grant (or idle), earliest next
//   ack in T+DATA_W+3+HOLDOFF.
// -----------------------------------------------------------------------------
module serial_link_tx_arbiter
   import serial_link_tx_arbiter_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int DATA_W  = LINK_ITEM_W,
   parameter int HOLDOFF = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   serial_link_tx_arbiter_if.slave  lnk,
   output tx_dbg_t                  dbg_o
);

   localparam int IDX_W   = $clog2(N_REQ);
   localparam int FRAME_W = DATA_W + 2;
   localparam int CNT_W   = $clog2(FRAME_W);
   localparam int HOLD_W  = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);

   typedef enum logic [TX_STATE_W-1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_HOLD = 2'd2
   } state_e;

   state_e              state_q;
   logic [FRAME_W-1:0]  shift_q;
   logic [CNT_W-1:0]    bit_cnt_q;
   logic [HOLD_W-1:0]   hold_cnt_q;
   logic [IDX_W-1:0]    rr_ptr_q;
   logic                serial_q;
   logic [N_REQ-1:0]    ack_q;
   logic [IDX_W-1:0]    grant_q;
   logic                active_q;
   logic                done_q;

   logic [N_REQ-1:0]    arb_gnt;
   logic [IDX_W-1:0]    arb_idx;
   logic [IDX_W-1:0]    rr_ptr_d;
   logic [DATA_W-1:0]   data_sel;
   logic [FRAME_W-1:0]  frame_d;
   logic                hold_done;
   logic                grant_d;

   rr_arbiter #(
      .N     (N_REQ),
      .IDX_W (IDX_W)
   ) u_rr_arbiter (
      .req     (lnk.req_valid),
      .ptr     (rr_ptr_q),
      .gnt     (arb_gnt),
      .gnt_idx (arb_idx)
   );

   assign hold_done = (hold_cnt_q == HOLD_W'(HOLDOFF));

   // Once the hold-off has elapsed, HOLD behaves like IDLE: a pending request
   // is granted on the same edge that channel_busy is seen low, so frames can
   // run back to back at the minimum period and a grant follows a falling
   // channel_busy by one cycle.
   assign grant_d = ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && hold_done))
                    && !lnk.channel_busy && (|lnk.req_valid);

   assign rr_ptr_d = (arb_idx == IDX_W'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
   assign data_sel = lnk.req_data[int'(arb_idx)*DATA_W +: DATA_W];
   // Guard (0) in the MSB, start (1) in the LSB: shifting right puts the start
   // bit on the line first.
   assign frame_d  = {1'b0, data_sel, 1'b1};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         hold_cnt_q <= '0;
         rr_ptr_q   <= '0;
         serial_q   <= 1'b0;
         ack_q      <= '0;
         grant_q    <= '0;
         active_q   <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         ack_q  <= '0;
         done_q <= 1'b0;

         case (state_q)
            ST_IDLE: begin
               serial_q <= 1'b0;
               active_q <= 1'b0;
            end

            ST_SEND: begin
               serial_q  <= shift_q[0];
               shift_q   <= shift_q >> 1;
               bit_cnt_q <= bit_cnt_q + 1'b1;
               active_q  <= 1'b1;
               // Guard bit goes onto the line with this edge.
               if (bit_cnt_q == CNT_W'(FRAME_W - 1)) begin
                  done_q     <= 1'b1;
                  state_q    <= ST_HOLD;
                  hold_cnt_q <= '0;
               end
            end

            ST_HOLD: begin
               serial_q <= 1'b0;
               if (!hold_done) begin
                  hold_cnt_q <= hold_cnt_q + 1'b1;
               end else if (!lnk.channel_busy) begin
                  state_q  <= ST_IDLE;
                  active_q <= 1'b0;
               end
            end

            default: begin
               state_q  <= ST_IDLE;
               serial_q <= 1'b0;
               active_q <= 1'b0;
            end
         endcase

         // A grant overrides the per-state updates above.
         if (grant_d) begin
            shift_q   <= frame_d;
            bit_cnt_q <= '0;
            ack_q     <= arb_gnt;
            grant_q   <= arb_idx;
            rr_ptr_q  <= rr_ptr_d;
            serial_q  <= 1'b0;
            active_q  <= 1'b0;
            state_q   <= ST_SEND;
         end
      end
   end

   assign lnk.serial_out  = serial_q;
   assign lnk.req_ack     = ack_q;
   assign lnk.grant_id    = grant_q;
   assign lnk.link_active = active_q;
   assign lnk.frame_done  = done_q;

   assign dbg_o.state     = state_q;
   assign dbg_o.hold_done = hold_done;

endmodule : serial_link_tx_arbiter
